// File: rtl/taxi_eth_phy_pkg.sv
// taxi_eth_phy_pkg: shared 10G PHY constants for 64b/66b block handling
package taxi_eth_phy_pkg;
  localparam int BLOCK_W = 66;
  localparam int SEQ_LEN = 33;
  localparam logic [5:0] STALL_SLOT = 6'(SEQ_LEN - 1);
  localparam logic [5:0] LAST_SLOT = STALL_SLOT - 6'd1;
  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;
endpackage

// File: rtl/taxi_eth_phy_10g_tx_gbx.sv
// taxi_eth_phy_10g_tx_gbx: 66b-to-64b TX gearbox, 32 blocks in, 33 words out per sequence
module taxi_eth_phy_10g_tx_gbx
  import taxi_eth_phy_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_valid,
  input  logic [HDR_W-1:0]  in_hdr,
  input  logic              in_hdr_valid,
  output logic              gbx_req_sync,
  output logic              gbx_req_stall,
  input  logic              gbx_sync,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_valid,
  output logic              stat_overflow,
  output logic              stat_underflow,
  output logic              stat_sync_err
);
  localparam int BUF_W = 128;
  if (DATA_W != 64 || HDR_W != 2) begin : g_bad_width
    $error("taxi_eth_phy_10g_tx_gbx supports only DATA_W=64 and HDR_W=2");
  end
  logic [5:0] cnt, cnt_nxt;
  logic [6:0] occ, occ_nxt;
  logic [7:0] occ_app;
  logic [BUF_W-1:0] bit_buf, buf_app, buf_nxt;
  logic vld, blk_slot, accept, emit, underflow, overflow, sync_err;
  always_comb begin
    vld = in_data_valid && in_hdr_valid;
    blk_slot = cnt != STALL_SLOT;
    accept = blk_slot && vld;
    underflow = blk_slot && !vld;
    overflow = !blk_slot && vld;
    sync_err = vld && (gbx_sync != (cnt == 6'd0));
    buf_app = accept ? bit_buf | ({{(BUF_W-BLOCK_W){1'b0}}, in_data, in_hdr} << occ) : bit_buf;
    occ_app = {1'b0, occ} + (accept ? 8'(BLOCK_W) : 8'd0);
    emit = !underflow && occ_app >= 8'd64;
    buf_nxt = underflow ? '0 : emit ? buf_app >> DATA_W : buf_app;
    occ_nxt = underflow ? '0 : emit ? 7'(occ_app - 8'd64) : occ_app[6:0];
    // a missing block resyncs by jumping straight to the stall slot
    cnt_nxt = underflow ? STALL_SLOT : cnt == STALL_SLOT ? 6'd0 : cnt + 6'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= STALL_SLOT;
      occ <= '0;
      bit_buf <= '0;
      out_data <= '0;
      out_data_valid <= 1'b0;
      gbx_req_sync <= 1'b1;
      gbx_req_stall <= 1'b0;
      stat_overflow <= 1'b0;
      stat_underflow <= 1'b0;
      stat_sync_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      occ <= occ_nxt;
      bit_buf <= buf_nxt;
      if (emit) out_data <= buf_app[DATA_W-1:0];
      out_data_valid <= emit;
      gbx_req_sync <= cnt_nxt == STALL_SLOT;
      gbx_req_stall <= cnt_nxt == LAST_SLOT;
      stat_overflow <= overflow;
      stat_underflow <= underflow;
      stat_sync_err <= sync_err;
    end
  end
endmodule

// File: tb/tb_taxi_eth_phy_10g_tx_gbx.sv
// tb_taxi_eth_phy_10g_tx_gbx: directed gearbox bench with a bit-level scoreboard
module tb_taxi_eth_phy_10g_tx_gbx;
  import taxi_eth_phy_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] in_data;
  logic in_data_valid;
  logic [1:0] in_hdr;
  logic in_hdr_valid;
  logic gbx_req_sync, gbx_req_stall, gbx_sync;
  logic [63:0] out_data;
  logic out_data_valid, stat_overflow, stat_underflow, stat_sync_err;
  int vectors = 0;
  int fails = 0;
  int word_cnt = 0;
  int mcnt = 32;
  bit q[$];
  logic [63:0] last_word = '0;

  taxi_eth_phy_10g_tx_gbx #(.DATA_W(64), .HDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_data_valid(in_data_valid),
    .in_hdr(in_hdr), .in_hdr_valid(in_hdr_valid),
    .gbx_req_sync(gbx_req_sync), .gbx_req_stall(gbx_req_stall), .gbx_sync(gbx_sync),
    .out_data(out_data), .out_data_valid(out_data_valid),
    .stat_overflow(stat_overflow), .stat_underflow(stat_underflow), .stat_sync_err(stat_sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive a slot, push accepted bits, then check what the edge produced
  task automatic tick(input bit v, input logic [63:0] d, input logic [1:0] h, input bit s);
    logic [65:0] blk;
    logic [63:0] ew;
    bit slot_ok, e_ovf, e_unf, e_se, e_vld;
    blk = {d, h};
    slot_ok = mcnt != 32;
    e_ovf = !slot_ok && v;
    e_unf = slot_ok && !v;
    e_se = v && (s != (mcnt == 0));
    in_data = d;
    in_hdr = h;
    in_data_valid = v;
    in_hdr_valid = v;
    gbx_sync = s;
    if (slot_ok && v) for (int i = 0; i < 66; i++) q.push_back(blk[i]);
    e_vld = !e_unf && q.size() >= 64;
    @(posedge clk);
    #1;
    mcnt = e_unf ? 32 : (mcnt == 32 ? 0 : mcnt + 1);
    chk("out_data_valid", out_data_valid, e_vld);
    if (e_vld) begin
      for (int i = 0; i < 64; i++) ew[i] = q.pop_front();
      last_word = ew;
      word_cnt++;
    end
    chk("out_data", out_data, last_word);
    chk("stat_overflow", stat_overflow, e_ovf);
    chk("stat_underflow", stat_underflow, e_unf);
    chk("stat_sync_err", stat_sync_err, e_se);
    chk("gbx_req_sync", gbx_req_sync, mcnt == 32);
    chk("gbx_req_stall", gbx_req_stall, mcnt == 31);
    if (e_unf) q.delete();
  endtask

  task automatic run_to(input int target);
    while (mcnt != target) tick(mcnt != 32, {$urandom, $urandom}, 2'($urandom), mcnt == 0);
  endtask

  task automatic check_reset();
    chk("rst_out_data_valid", out_data_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_req_sync", gbx_req_sync, 1);
    chk("rst_req_stall", gbx_req_stall, 0);
    chk("rst_stat_overflow", stat_overflow, 0);
    chk("rst_stat_underflow", stat_underflow, 0);
    chk("rst_stat_sync_err", stat_sync_err, 0);
  endtask

  initial begin
    int blocks;
    logic [63:0] d;
    rst_n = 1'b0;
    in_data = '0;
    in_hdr = '0;
    in_data_valid = 1'b0;
    in_hdr_valid = 1'b0;
    gbx_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    mcnt = 32;
    blocks = 0;
    word_cnt = 0;
    while (blocks < 320) begin
      if (mcnt != 32) blocks++;
      tick(mcnt != 32, {$urandom, $urandom}, 2'($urandom), mcnt == 0);
    end
    tick(0, '0, '0, 0);
    chk("steady_word_count", 64'(word_cnt), 330);
    chk("steady_bits_left", 64'(q.size()), 0);
    run_to(5);
    tick(1, {$urandom, $urandom}, HDR_DATA, 1);
    run_to(32);
    tick(1, 64'hDEAD_BEEF_0000_0001, HDR_DATA, 0);
    run_to(10);
    tick(0, '0, '0, 0);
    chk("gap_req_sync", gbx_req_sync, 1);
    tick(0, '0, '0, 0);
    d = 64'h1E;
    tick(1, d, HDR_CTRL, 1);
    chk("realign_word", out_data, {d[61:0], HDR_CTRL});
    chk("hdr_order_lsb", 64'(out_data[7:0]), 64'h7A);
    run_to(17);
    rst_n = 1'b0;
    in_data_valid = 1'b0;
    in_hdr_valid = 1'b0;
    gbx_sync = 1'b0;
    @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    mcnt = 32;
    q.delete();
    last_word = '0;
    run_to(0);
    run_to(32);
    tick(0, '0, '0, 0);
    chk("final_bits_left", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
